// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset controller: sequences FETCH/DECODE/EXEC/MEM/WB/MDWAIT and
// gates datapath write strobes; select lines are a pure decode of the held IR fields.
module multicycle_control #(
  parameter int unsigned MEM_WAIT  = 0,
  parameter int unsigned MD_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       cmp_eq,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] NPCOp,
  output logic [1:0] EXTOp,
  output logic [2:0] ALUOp,
  output logic       BSel,
  output logic [1:0] SSel,
  output logic [1:0] LSel,
  output logic [1:0] M1Sel,
  output logic [1:0] M2Sel,
  output logic       M3Sel,
  output logic       HLRd,
  output logic       HLSel,
  output logic       RFWr,
  output logic       DMWr,
  output logic       HiLoWr,
  output logic       MDStart,
  output logic       busy,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL    = 6'h00;
  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_MFHI   = 6'h10;
  localparam logic [5:0] F_MFLO   = 6'h12;
  localparam logic [5:0] F_MULT   = 6'h18;
  localparam logic [5:0] F_DIV    = 6'h1A;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUBU   = 6'h23;
  localparam logic [5:0] F_SLT    = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    I_NONE, I_ALU, I_LUI, I_LOAD, I_STORE, I_BR, I_J, I_JAL, I_JR, I_MD, I_MF
  } icls_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  icls_e              icls;
  logic [1:0]         npc_dec;

  // Instruction class and datapath selects from the held op/funct.
  always_comb begin
    icls    = I_NONE;
    npc_dec = 2'b00;
    EXTOp   = 2'b00;
    ALUOp   = 3'b000;
    BSel    = 1'b0;
    SSel    = 2'b00;
    LSel    = 2'b00;
    M1Sel   = 2'b00;
    M2Sel   = 2'b00;
    M3Sel   = 1'b0;
    HLRd    = 1'b0;
    HLSel   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU: begin icls = I_ALU; M1Sel = 2'b01; M2Sel = 2'b10; ALUOp = 3'b000; end
          F_SUBU: begin icls = I_ALU; M1Sel = 2'b01; M2Sel = 2'b10; ALUOp = 3'b001; end
          F_SLL:  begin icls = I_ALU; M1Sel = 2'b01; M2Sel = 2'b10; ALUOp = 3'b011; end
          F_SLT:  begin icls = I_ALU; M1Sel = 2'b01; M2Sel = 2'b10; ALUOp = 3'b100; end
          F_JR:   begin icls = I_JR;  npc_dec = 2'b11; end
          F_MULT: icls = I_MD;
          F_DIV:  icls = I_MD;
          F_MFHI: begin icls = I_MF; M1Sel = 2'b01; HLRd = 1'b1; HLSel = 1'b1; end
          F_MFLO: begin icls = I_MF; M1Sel = 2'b01; HLRd = 1'b1; HLSel = 1'b0; end
          default: icls = I_NONE;
        endcase
      end
      OP_ORI: begin icls = I_ALU; ALUOp = 3'b010; M3Sel = 1'b1; M2Sel = 2'b10; end
      OP_LUI: begin icls = I_LUI; EXTOp = 2'b10; M2Sel = 2'b11; end
      OP_LW:  begin icls = I_LOAD; EXTOp = 2'b01; M3Sel = 1'b1; M2Sel = 2'b01; LSel = 2'b00; end
      OP_LH:  begin icls = I_LOAD; EXTOp = 2'b01; M3Sel = 1'b1; M2Sel = 2'b01; LSel = 2'b01; end
      OP_LB:  begin icls = I_LOAD; EXTOp = 2'b01; M3Sel = 1'b1; M2Sel = 2'b01; LSel = 2'b10; end
      OP_SW:  begin icls = I_STORE; EXTOp = 2'b01; M3Sel = 1'b1; SSel = 2'b00; end
      OP_SH:  begin icls = I_STORE; EXTOp = 2'b01; M3Sel = 1'b1; SSel = 2'b01; end
      OP_SB:  begin icls = I_STORE; EXTOp = 2'b01; M3Sel = 1'b1; SSel = 2'b10; end
      OP_BEQ: begin icls = I_BR; npc_dec = 2'b01; EXTOp = 2'b01; ALUOp = 3'b001; end
      OP_BNE: begin icls = I_BR; npc_dec = 2'b01; EXTOp = 2'b01; ALUOp = 3'b001; BSel = 1'b1; end
      OP_J:   begin icls = I_J;   npc_dec = 2'b10; end
      OP_JAL: begin icls = I_JAL; npc_dec = 2'b10; M1Sel = 2'b10; M2Sel = 2'b00; end
      default: icls = I_NONE;
    endcase
  end

  // Next state, wait counter and strobes; reset low masks every strobe in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    NPCOp   = npc_dec;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    HiLoWr  = 1'b0;
    MDStart = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        NPCOp   = 2'b00;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (icls)
          I_J, I_JR: begin PCWr = 1'b1; state_d = S_FETCH; end
          I_JAL:     begin PCWr = 1'b1; RFWr = 1'b1; state_d = S_FETCH; end
          I_NONE:    state_d = S_FETCH;
          default:   state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (icls)
          I_BR: begin PCWr = cmp_eq ^ BSel; state_d = S_FETCH; end
          I_LOAD, I_STORE: begin cnt_d = CNT_W'(MEM_WAIT); state_d = S_MEM; end
          I_MD: begin MDStart = 1'b1; cnt_d = CNT_W'(MD_CYCLES - 1); state_d = S_MDWAIT; end
          I_ALU, I_LUI, I_MF: state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (icls == I_STORE) begin
          DMWr    = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        RFWr    = 1'b1;
        state_d = S_FETCH;
      end
      S_MDWAIT: begin
        busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          HiLoWr  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (!reset) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RFWr    = 1'b0;
      DMWr    = 1'b0;
      HiLoWr  = 1'b0;
      MDStart = 1'b0;
      busy    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle controller for the MIPS-subset CPU, replacing the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and asserts write enables only in the state where they apply. It adds parametrised data-memory wait states and a parametrised multi-cycle MULT/DIV unit with HI/LO access. It sits between the IR/comparator outputs and every datapath write enable and mux select.

## Interface
- MEM_WAIT, 0, extra data-memory cycles per load/store; range 0..255
- MD_CYCLES, 5, MULT/DIV latency in cycles; range 1..255
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; 0 at a rising edge resets the block
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- cmp_eq  in  1  rs==rt from the comparator, valid in EXEC
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- NPCOp  out  2  00 PC+4, 01 branch target, 10 j/jal target, 11 rs (jr)
- EXTOp  out  2  00 zero-extend, 01 sign-extend, 10 lui (imm<<16)
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 sll, 100 slt
- BSel  out  1  1 = bne (branch on !cmp_eq)
- SSel  out  2  store width: 00 word, 01 half, 10 byte
- LSel  out  2  load width: 00 word, 01 half, 10 byte
- M1Sel  out  2  RF write address: 00 rt, 01 rd, 10 $31
- M2Sel  out  2  RF write data: 00 PC+4, 01 DM, 10 ALU, 11 EXT
- M3Sel  out  1  ALU B operand: 0 rt, 1 EXT
- HLRd  out  1  1 = RF write data from HI/LO (overrides M2Sel)
- HLSel  out  1  0 = LO, 1 = HI
- RFWr, DMWr, HiLoWr, MDStart  out  1 each  write/start strobes
- busy  out  1  high in MDWAIT
- state  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5. Encodings 6 and 7 are illegal and return to FETCH.
- Supported instructions:
  - addu, subu, sll, slt: op 0; funct 100001, 100011, 000000, 101010.
  - ori, lui, lw, lh, lb, sw, sh, sb, beq, bne, j, jal.
  - jr: funct 001000.
  - mult, div: funct 011000, 011010.
  - mfhi, mflo: funct 010000, 010010.
- Select outputs (NPCOp, EXTOp, ALUOp, BSel, SSel, LSel, M1/M2/M3Sel, HLRd, HLSel) are decoded combinationally from op/funct in every state. Encodings are as listed under Interface.
- Strobes (PCWr, IRWr, RFWr, DMWr, HiLoWr, MDStart) are 0 except as listed below.
- FETCH: IRWr=1, PCWr=1, NPCOp forced 00. Next state DECODE.
- DECODE:
  - j: PCWr=1 (NPCOp 10), go to FETCH.
  - jal: PCWr=1 and RFWr=1 (M1Sel 10, M2Sel 00), go to FETCH.
  - jr: PCWr=1 (NPCOp 11), go to FETCH.
  - Undefined op/funct: no strobes, go to FETCH (treated as nop).
  - Anything else: go to EXEC.
- EXEC:
  - beq/bne: PCWr = cmp_eq XOR BSel, NPCOp 01, go to FETCH.
  - Loads/stores: load cnt=MEM_WAIT, go to MEM.
  - mult/div: MDStart=1, load cnt=MD_CYCLES-1, go to MDWAIT.
  - ALU ops, lui, mfhi/mflo: go to WB.
- MEM:
  - If cnt!=0: decrement cnt, stay in MEM.
  - If cnt==0, store: DMWr=1, go to FETCH.
  - If cnt==0, load: go to WB.
- WB: RFWr=1, go to FETCH.
- MDWAIT: busy=1.
  - If cnt!=0: decrement cnt.
  - If cnt==0: HiLoWr=1, go to FETCH.
- cnt is 8 bits and never wraps. Decrement happens only when cnt is nonzero.

## Timing
- Cycles per instruction:
  - j, jal, jr: 2.
  - beq/bne: 3.
  - ALU ops, lui, mfhi/mflo: 4.
  - Stores: 4+MEM_WAIT.
  - Loads: 5+MEM_WAIT.
  - mult/div: 3+MD_CYCLES.
- DMWr is high for exactly one cycle per store, the last MEM cycle. With MEM_WAIT=0 there is one MEM cycle.
- HiLoWr is high for exactly one cycle, MD_CYCLES cycles after MDStart. With MD_CYCLES=1 it falls in the first MDWAIT cycle.
- Reset:
  - While reset=0, all strobes and busy are forced to 0 combinationally.
  - At the edge: state←FETCH, cnt←0.
  - The first cycle after reset rises is FETCH.
- Reset asserted mid-instruction (including in MDWAIT or MEM) aborts the instruction. No strobe fires in the reset cycle.
- op/funct changes are ignored outside the IRWr cycle because the IR holds them. The decode of the current op/funct is used in every state.

## Test plan
- Reset, then addu (op 0, funct 100001): states 0→1→2→4→0. RFWr=1 only in cycle 4, with M1Sel=01, M2Sel=10, ALUOp=000. PCWr and IRWr only in cycle 1.
- MEM_WAIT=2, sw then lw: sw shows MEM for 3 cycles, DMWr=1 only on the 3rd, total 6 cycles. lw gives RFWr=1 in WB, M2Sel=01, EXTOp=01, total 7 cycles.
- beq with cmp_eq=1, then bne with cmp_eq=1: beq gives PCWr=1 in EXEC with NPCOp=01. bne gives PCWr=0 in EXEC. Both take 3 cycles.
- MD_CYCLES=5, mult then mfhi: MDStart=1 in EXEC, busy=1 for 5 cycles, HiLoWr=1 on the 5th only, total 8 cycles. mfhi gives RFWr=1 with HLRd=1, HLSel=1.
- jal: 2 cycles, with RFWr=1, M1Sel=10, M2Sel=00 and PCWr=1 in DECODE. jr: NPCOp=11 in DECODE. Undefined op 111111: 2 cycles, no strobes after FETCH.
- reset=0 in the 3rd MDWAIT cycle: HiLoWr is never asserted, strobes are 0 in the reset cycle, and the next cycle is FETCH with cnt=0.
